fifo_rd_ctrl: RTL
=================

Name: fifo_rd_ctrl

Overview:
Downstream consumer of the 8x256 single-clock FIFO. Waits until the FIFO holds a burst threshold of words, then drains it in bursts. Absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer. Presents data on a valid/ready stream to the next stage, such as a UART/SPI transmitter or a packer.

Parameters:
DATA_W, 8, data width; must equal FIFO width
USEDW_W, 8, width of FIFO usedw
BURST_THR, 128, usedw level (>=) that starts a burst
TIMEOUT, 1000, idle cycles before a partial flush; used only with RD_TIMEOUT_EN

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
empty  in  1  FIFO empty flag
full  in  1  FIFO full flag
usedw  in  USEDW_W  FIFO fill level
fifo_q  in  DATA_W  FIFO read data, valid one cycle after rd_req
rd_req  out  1  FIFO read request
po_data  out  DATA_W  stream data (head of skid buffer)
po_valid  out  1  stream data valid
po_ready  in  1  downstream accept
burst_done  out  1  one-cycle pulse when a burst ends
burst_cnt  out  16  words read in current/last burst, saturating at 16'hFFFF

Behaviour:
- Clock and reset: one clock, sys_clk. sys_rst_n is asynchronous, active-low.
- Reset values: state=IDLE; rd_req=0; po_valid=0; po_data=0; burst_done=0; burst_cnt=0; skid buffer count=0; in-flight flag=0.
- State machine, IDLE -> BURST:
  - taken when usedw >= BURST_THR, or when full=1 (covers the wrap of usedw to 0 when 256 words are held).
  - burst_cnt clears to 0 on this transition.
- State machine, BURST -> IDLE:
  - taken on the first cycle where empty=1 and rd_req=0.
  - burst_done pulses high for exactly that cycle.
- Read issue: rd_req = (state==BURST) & ~empty & (cnt + inflight - pop < 2).
  - inflight = rd_req registered by one cycle.
  - pop = po_valid & po_ready.
  - rd_req is never asserted while empty=1, so the FIFO never underflows.
- Capture: when inflight=1, fifo_q is written to the buffer tail that cycle.
  - Simultaneous capture and pop leaves cnt unchanged and keeps order.
- Stream rules:
  - po_valid = (cnt != 0).
  - po_data stays stable while po_valid=1 & po_ready=0.
  - First word reaches po_valid 2 cycles after the first rd_req.
  - Sustained throughput is 1 word/cycle while po_ready=1.
- Backpressure: with po_ready=0, at most 2 words are read beyond the last pop, then rd_req deasserts until a pop.
- burst_cnt increments on each rd_req cycle in BURST and saturates.
- Burst end with data buffered: the skid buffer keeps draining after the return to IDLE. A new burst may start while buffered words remain.
- Reset mid-burst: all state clears immediately. A word in flight or in the buffer is discarded, because the FIFO has already popped it. Upstream owns that loss.

Optional Feature:
RD_TIMEOUT_EN
- Defined:
  - A 16-bit idle counter runs in IDLE while empty=0 and usedw < BURST_THR.
  - It clears when empty=1 or on leaving IDLE.
  - When it reaches TIMEOUT-1, IDLE -> BURST is forced, flushing a partial burst.
- Undefined: no counter is present; bursts start on threshold or full only.

Decomposition:
- Shared package fifo_rd_pkg holds:
  - the state typedef {IDLE, BURST};
  - the constants SKID_DEPTH=2 and BURST_CNT_W=16.
- One natural sub-module: skid_buf_2, a 2-entry valid/ready buffer with push, pop, cnt, head data.
- The FSM and read-issue logic stay in fifo_rd_ctrl.

Test Plan:
- Write 127 words, no reads -> rd_req stays 0. Write 1 more (usedw=128) -> BURST entered, 128 words out in order, burst_done pulses once, burst_cnt=128.
- po_ready=1 throughout a 128-word burst -> rd_req high for 128 consecutive cycles, po_valid high 128 consecutive cycles starting 2 cycles after the first rd_req.
- po_ready toggles 1-0-0-1 pseudo-randomly -> no word lost or duplicated, at most 2 reads ahead of the last pop, rd_req never high while empty=1.
- Fill FIFO to 256 (full=1, usedw=0) -> burst starts on full, 256 words drained, burst_cnt=256.
- Assert sys_rst_n=0 mid-burst after 10 words -> all outputs 0 the same cycle. After release, no rd_req until the threshold is met again.
- RD_TIMEOUT_EN, TIMEOUT=1000, write 5 words -> burst forced after 1000 idle cycles, 5 words out, burst_done pulses. Without the macro, no reads occur.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO burst read controller.
package fifo_rd_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} rd_state_e;

  localparam int SKID_DEPTH  = 2;
  localparam int BURST_CNT_W = 16;
  localparam int SKID_CNT_W  = $clog2(SKID_DEPTH + 1);
endpackage

// File: rtl/skid_buf_2.sv
// Two-entry valid/ready buffer: head register feeds the stream, tail absorbs one extra word.
module skid_buf_2
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_W-1:0]     din,
  input  logic                  pop,
  output logic [SKID_CNT_W-1:0] cnt,
  output logic [DATA_W-1:0]     head
);
  logic [DATA_W-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == '0) head <= din;
          else           tail <= din;
          cnt <= cnt + SKID_CNT_W'(1);
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - SKID_CNT_W'(1);
        end
        // Simultaneous push/pop: count holds, tail slides forward to keep order.
        2'b11: begin
          if (cnt == SKID_CNT_W'(SKID_DEPTH)) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst drain controller for a single-clock FIFO with a 1-cycle read latency.
// Optional idle-timeout partial flush is enabled by defining RD_TIMEOUT_EN.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int USEDW_W   = 8,
  parameter int BURST_THR = 128,
  parameter int TIMEOUT   = 1000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   empty,
  input  logic                   full,
  input  logic [USEDW_W-1:0]     usedw,
  input  logic [DATA_W-1:0]      fifo_q,
  output logic                   rd_req,
  output logic [DATA_W-1:0]      po_data,
  output logic                   po_valid,
  input  logic                   po_ready,
  output logic                   burst_done,
  output logic [BURST_CNT_W-1:0] burst_cnt
);
  rd_state_e             state;
  logic                  inflight;
  logic                  pop;
  logic                  below_thr;
  logic                  tmo_hit;
  logic                  start;
  logic [SKID_CNT_W-1:0] sk_cnt;
  logic [SKID_CNT_W:0]   occ;
  logic [SKID_CNT_W:0]   room;

  assign pop       = po_valid & po_ready;
  assign po_valid  = (sk_cnt != '0);
  assign below_thr = (usedw < USEDW_W'(BURST_THR));

  // Words held plus the one in flight must leave a slot for the next read.
  assign occ  = {1'b0, sk_cnt} + {{SKID_CNT_W{1'b0}}, inflight};
  assign room = (SKID_CNT_W+1)'(SKID_DEPTH) + {{SKID_CNT_W{1'b0}}, pop};

  assign rd_req     = (state == BURST) & ~empty & (occ < room);
  assign burst_done = (state == BURST) & empty & ~rd_req;
  assign start      = (state == IDLE) & (~below_thr | full | tmo_hit);

`ifdef RD_TIMEOUT_EN
  logic [15:0] idle_cnt;
  assign tmo_hit = (idle_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                              idle_cnt <= '0;
    else if (state != IDLE || empty || start)    idle_cnt <= '0;
    else if (below_thr)                          idle_cnt <= idle_cnt + 16'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= rd_req;
      unique case (state)
        IDLE: if (start) begin
          state     <= BURST;
          burst_cnt <= '0;
        end
        BURST: begin
          if (burst_done) state <= IDLE;
          if (rd_req && burst_cnt != '1) burst_cnt <= burst_cnt + BURST_CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  skid_buf_2 #(.DATA_W(DATA_W)) u_skid (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (inflight),
    .din   (fifo_q),
    .pop   (pop),
    .cnt   (sk_cnt),
    .head  (po_data)
  );
endmodule
